// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: alignment check, lane generation, req/ack handshake
// with timeout, sub-word load extension and final MEM-stage result selection.
module mem_stage_lsu #(
    parameter int NBITS   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic [NBITS-1:0]   i_aluresult,
    input  logic [NBITS-1:0]   i_storedata,
    input  logic               i_memread,
    input  logic               i_memwrite,
    input  logic [1:0]         i_size,
    input  logic               i_unsigned,
    output logic               o_stall,
    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic [NBITS-1:0]   o_mem_addr,
    output logic [NBITS-1:0]   o_mem_wdata,
    output logic [NBITS/8-1:0] o_mem_be,
    input  logic               i_mem_ack,
    input  logic [NBITS-1:0]   i_mem_rdata,
    output logic               o_valid,
    output logic [NBITS-1:0]   o_memstgdata,
    output logic               o_misaligned,
    output logic               o_buserr
);

    localparam int NB = NBITS / 8;
    localparam int LW = $clog2(NB);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [NBITS-1:0]  addr_p1, wdata_p1;
    logic [NB-1:0]     be_p1;
    logic [LW-1:0]     lane_p1;
    logic [1:0]        size_p1;
    logic              we_p1, uns_p1;

    logic              memop, illegal, misal;
    logic [LW-1:0]     lane, align_mask;
    logic [NB-1:0]     be_d;
    logic [NBITS-1:0]  wdata_d;
    logic              stall_d, accept, passthru, misal_evt, done, tohit;

    // Shift the addressed lane down and sign/zero-extend the selected field.
    function automatic logic [NBITS-1:0] load_ext(input logic [NBITS-1:0] rdata,
                                                  input logic [1:0] size,
                                                  input logic uns,
                                                  input logic [LW-1:0] ln);
        logic [NBITS-1:0] sh;
        logic [NBITS-1:0] res;
        logic             ext;
        int               nb;
        sh = rdata >> {ln, 3'b000};
        nb = 8 << size;
        if (nb > NBITS) nb = NBITS;
        ext = ~uns & sh[nb-1];
        for (int i = 0; i < NBITS; i++) res[i] = (i < nb) ? sh[i] : ext;
        return res;
    endfunction

    always_comb begin
        memop      = i_memread | i_memwrite;
        lane       = i_aluresult[LW-1:0];
        illegal    = (32'd8 << i_size) > NBITS;
        align_mask = LW'((32'd1 << i_size) - 32'd1);
        misal      = |(lane & align_mask);
        be_d       = '0;
        wdata_d    = '0;
        for (int b = 0; b < NB; b++) begin
            be_d[b] = (b >= int'(lane)) && (b < int'(lane) + (1 << i_size));
            wdata_d[b*8 +: 8] = i_storedata[(b & ((1 << i_size) - 1))*8 +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        stall_d   = 1'b0;
        accept    = 1'b0;
        passthru  = 1'b0;
        misal_evt = 1'b0;
        done      = 1'b0;
        tohit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    if (!memop) begin
                        passthru = 1'b1;
                    end else if (illegal || misal) begin
                        misal_evt = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        stall_d = 1'b1;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // Ack takes priority over an expiring timeout in the same cycle.
                if (i_mem_ack) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    tohit   = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_stall     = stall_d & ~i_rst;
    assign o_mem_req   = (state_q == ACCESS);
    assign o_mem_we    = we_p1;
    assign o_mem_addr  = {addr_p1[NBITS-1:LW], {LW{1'b0}}};
    assign o_mem_wdata = wdata_p1;
    assign o_mem_be    = be_p1;

    // ---- EX/MEM -> access latch and MEM/WB result register ----
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_p1      <= '0;
            wdata_p1     <= '0;
            be_p1        <= '0;
            lane_p1      <= '0;
            size_p1      <= '0;
            we_p1        <= 1'b0;
            uns_p1       <= 1'b0;
            o_valid      <= 1'b0;
            o_misaligned <= 1'b0;
            o_buserr     <= 1'b0;
            o_memstgdata <= '0;
        end else begin
            state_q      <= state_d;
            o_valid      <= passthru | done;
            o_misaligned <= misal_evt;
            o_buserr     <= tohit;
            if (accept) begin
                cnt_q    <= '0;
                addr_p1  <= i_aluresult;
                wdata_p1 <= wdata_d;
                be_p1    <= be_d;
                lane_p1  <= lane;
                size_p1  <= i_size;
                we_p1    <= ~i_memread;
                uns_p1   <= i_unsigned;
            end else if (state_q == ACCESS && !done && !tohit) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (passthru) begin
                o_memstgdata <= i_aluresult;
            end else if (done) begin
                o_memstgdata <= we_p1 ? addr_p1
                                      : load_ext(i_mem_rdata, size_p1, uns_p1, lane_p1);
            end
        end
    end

endmodule
